// File: rtl/iot_byte_feeder_pkg.sv
// Shared types and constants for the IoT byte feeder and the filter-side benches.
// Holds word/byte geometry, the FIFO entry layout and the filter function encodings.
package iot_byte_feeder_pkg;

    localparam int IOT_WORD_W         = 128;
    localparam int IOT_BYTE_W         = 8;
    localparam int IOT_BYTES_PER_WORD = 16;

    typedef enum logic [2:0] {
        FN_NONE  = 3'd0,
        ENCRYPT  = 3'd1,
        DECRYPT  = 3'd2,
        CRC_GEN  = 3'd3,
        TOP2MAX  = 3'd4,
        LAST2MIN = 3'd5
    } fn_sel_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } head_state_t;

    // One buffered word: 128 data bits plus the end-of-stream flag.
    typedef struct packed {
        logic                  last;
        logic [IOT_WORD_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/iot_byte_feeder_if.sv
// Word-side handshake and byte-side filter link of the feeder, bundled as one interface.
// master drives words and filter flow control; slave is the feeder itself.
interface iot_byte_feeder_if;
    import iot_byte_feeder_pkg::*;

    logic                  word_valid;
    logic [IOT_WORD_W-1:0] word_data;
    logic                  word_last;
    logic                  word_ready;
    logic                  halt;
    logic                  busy;
    logic                  in_en;
    logic [IOT_BYTE_W-1:0] iot_in;

    modport master (
        output word_valid, word_data, word_last, halt, busy,
        input  word_ready, in_en, iot_in
    );

    modport slave (
        input  word_valid, word_data, word_last, halt, busy,
        output word_ready, in_en, iot_in
    );

endinterface

// File: rtl/iot_word_fifo.sv
// Synchronous word FIFO with full/empty flags; head entry is readable without latency
// so the byte mux can present byte 0 the cycle after a push into an empty FIFO.
module iot_word_fifo
    import iot_byte_feeder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_en,
    input  fifo_entry_t i_wr_data,
    input  logic        i_rd_en,
    output fifo_entry_t o_rd_data,
    output logic        o_full,
    output logic        o_empty
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_wr_fire;
    logic        w_rd_fire;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_wr_fire = i_wr_en && !o_full;
    assign w_rd_fire = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_fire) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/iot_byte_feeder.sv
// Buffers 128-bit words and serialises them byte 0..15 onto the filter's in_en/iot_in
// link, stalling on busy/halt and reporting sent words and end of stream.
module iot_byte_feeder
    import iot_byte_feeder_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    iot_byte_feeder_if.slave bus,
    output logic [CNT_W-1:0] words_sent,
    output logic             stream_done
);

    localparam int IDX_W = $clog2(IOT_BYTES_PER_WORD);

    fifo_entry_t           w_wr_entry;
    fifo_entry_t           w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_in_en;
    logic                  w_pop;
    head_state_t           w_state;
    logic [IOT_BYTE_W-1:0] w_bytes [IOT_BYTES_PER_WORD];

    logic [IDX_W-1:0]      r_byte_idx;
    logic [CNT_W-1:0]      r_words_sent;
    logic                  r_stream_done;

    // Head state is a view of the FIFO occupancy, never a separate register.
    assign w_state = w_empty ? ST_EMPTY : ST_SEND;

    assign w_wr_entry.last = bus.word_last;
    assign w_wr_entry.data = bus.word_data;

    assign bus.word_ready = !w_full && !rst;
    assign w_push         = bus.word_valid && bus.word_ready;

    // busy arrives registered from the filter, so it gates the strobe directly.
    assign w_in_en   = (w_state == ST_SEND) && !bus.busy && !bus.halt && !rst;
    assign w_pop     = w_in_en && (r_byte_idx == IDX_W'(IOT_BYTES_PER_WORD - 1));
    assign bus.in_en = w_in_en;

    generate
        for (genvar gi = 0; gi < IOT_BYTES_PER_WORD; gi++) begin : g_byte_lane
            assign w_bytes[gi] = w_head.data[gi*IOT_BYTE_W +: IOT_BYTE_W];
        end
    endgenerate

    assign bus.iot_in = ((w_state == ST_EMPTY) || rst) ? '0 : w_bytes[r_byte_idx];

    iot_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_push),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_idx    <= '0;
            r_words_sent  <= '0;
            r_stream_done <= 1'b0;
        end else begin
            r_stream_done <= w_pop && w_head.last;
            if (w_in_en) r_byte_idx   <= r_byte_idx + 1'b1;
            if (w_pop)   r_words_sent <= r_words_sent + CNT_W'(1);
        end
    end

    assign words_sent  = r_words_sent;
    assign stream_done = r_stream_done;

endmodule

// File: tb/tb_iot_byte_feeder.sv
// Scoreboard bench for iot_byte_feeder: stimulus queues expected bytes on each accepted
// word; a negedge monitor checks every strobe, byte, ready, count and done pulse.
module tb_iot_byte_feeder;
    import iot_byte_feeder_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] words_sent;
    logic             stream_done;

    always #5 clk = ~clk;

    iot_byte_feeder_if bus ();

    iot_byte_feeder #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .words_sent  (words_sent),
        .stream_done (stream_done)
    );

    typedef struct {
        logic [7:0] b;
        bit         eow;
        bit         last;
    } exp_t;

    exp_t             sb_q [$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] exp_words = '0;
    bit               exp_done = 1'b0;
    int               words_held;
    bit               exp_en;
    exp_t             mon_e;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: expectations are formed before the byte accepted at the next edge is popped.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_en", {31'd0, bus.in_en}, 32'd0);
            chk("rst_iot_in", {24'd0, bus.iot_in}, 32'd0);
            chk("rst_word_ready", {31'd0, bus.word_ready}, 32'd0);
            sb_q.delete();
            exp_words = '0;
            exp_done  = 1'b0;
        end else begin
            words_held = (sb_q.size() + 15) / 16;
            exp_en     = (sb_q.size() != 0) && !bus.busy && !bus.halt;
            chk("word_ready", {31'd0, bus.word_ready}, {31'd0, words_held < DEPTH});
            chk("in_en", {31'd0, bus.in_en}, {31'd0, exp_en});
            chk("iot_in", {24'd0, bus.iot_in}, (sb_q.size() != 0) ? {24'd0, sb_q[0].b} : 32'd0);
            chk("words_sent", {16'd0, words_sent}, {16'd0, exp_words});
            chk("stream_done", {31'd0, stream_done}, {31'd0, exp_done});
            exp_done = 1'b0;
            if (exp_en) begin
                mon_e = sb_q.pop_front();
                $display("byte %02h accepted eow=%0d last=%0d", mon_e.b, mon_e.eow, mon_e.last);
                if (mon_e.eow) begin
                    exp_words = exp_words + 1'b1;
                    exp_done  = mon_e.last;
                end
            end
        end
    end

    task automatic send_word(input logic [127:0] d, input bit last);
        bit acc;
        exp_t e;
        acc = 1'b0;
        bus.word_valid = 1'b1;
        bus.word_data  = d;
        bus.word_last  = last;
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge clk);
            acc = bus.word_ready;
            @(posedge clk);
            #1;
        end
        bus.word_valid = 1'b0;
        checks++;
        if (acc) begin
            $display("word %032h last=%0d pushed", d, last);
            for (int k = 0; k < 16; k++) begin
                e.b    = d[8*k +: 8];
                e.eow  = (k == 15);
                e.last = last && (k == 15);
                sb_q.push_back(e);
            end
        end else begin
            errors++;
            $display("FAIL push_timeout: got ready=0 expected ready=1 within 300 cycles");
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d bytes pending expected 0", sb_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        bus.word_valid = 1'b0;
        bus.word_data  = '0;
        bus.word_last  = 1'b0;
        bus.busy       = 1'b0;
        bus.halt       = 1'b0;
        cycles(3);
        rst = 1'b0;
        cycles(2);

        // Single word, byte k = k, flagged last.
        send_word(128'h0F0E0D0C0B0A09080706050403020100, 1'b1);
        wait_drain();

        // busy stall in the middle of a word.
        send_word(128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 1'b0);
        cycles(5);
        bus.busy = 1'b1;
        cycles(2);
        bus.busy = 1'b0;
        wait_drain();

        // halt stall in the middle of a word.
        send_word(128'h00112233445566778899AABBCCDDEEFF, 1'b1);
        cycles(3);
        bus.halt = 1'b1;
        cycles(3);
        bus.halt = 1'b0;
        wait_drain();

        // Back-to-back words: FIFO fills, fifth word waits for a free slot.
        send_word(128'h1111111111111111111111111111AA01, 1'b0);
        send_word(128'h2222222222222222222222222222BB02, 1'b1);
        send_word(128'h3333333333333333333333333333CC03, 1'b0);
        send_word(128'h4444444444444444444444444444DD04, 1'b0);
        send_word(128'h5555555555555555555555555555EE05, 1'b1);
        wait_drain();

        // Reset in the middle of a word discards it; next word starts at byte 0.
        send_word(128'hA7A6A5A4A3A2A1A09F9E9D9C9B9A9998, 1'b1);
        cycles(8);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(2);
        send_word(128'hFEDCBA9876543210F0F1F2F3F4F5F6F7, 1'b1);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/iot_byte_feeder.md
Name: iot_byte_feeder

Overview:
- Upstream stage of the IoT data filter. Accepts 128-bit data words from a memory/DMA side over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each word into 16 bytes on the filter's in_en/iot_in interface, honouring the filter's busy stall.
- Byte k of a word is bits [8k+7:8k] and is sent in order k=0..15, so the filter's byte-indexed packing reassembles the word unchanged.
- Reports completed-word count and an end-of-stream pulse.

Parameters:
- DEPTH, 4, FIFO depth in words; power of two, >= 2
- CNT_W, 16, width of the sent-word counter

Ports:
- clk  in  1  clock, single domain
- rst  in  1  synchronous, active-high reset
- word_valid  in  1  upstream word available
- word_data  in  128  upstream word
- word_last  in  1  marks final word of the stream; sampled with word_data
- word_ready  out  1  FIFO can accept a word
- halt  in  1  pause byte issue without losing position
- busy  in  1  filter stall request, registered inside the filter
- in_en  out  1  byte strobe to filter
- iot_in  out  8  byte to filter
- words_sent  out  CNT_W  count of fully transmitted words
- stream_done  out  1  one-cycle pulse after last byte of a word_last word

Behaviour:
- Reset: clk and rst only, synchronous active-high.
  - Clears FIFO pointers, byte_idx, words_sent and stream_done.
  - Any partially sent word is discarded.
  - During and after reset: in_en=0, iot_in=0, word_ready=0 in the reset cycle, then word_ready=1.
- Push:
  - Word written when word_valid && word_ready at a rising edge.
  - word_ready = !full, registered-state-derived, with no combinational path from word_valid.
  - Entry width 129 bits: data plus last flag.
- Issue:
  - in_en = !empty && !busy && !halt, combinational from registered state and the busy/halt inputs.
  - busy is combinational into in_en because the filter's busy is already registered. A registered in_en would violate the stall by one cycle.
  - iot_in = head_data[8*byte_idx +: 8] when !empty, else 0. iot_in may change only when in_en fires or the head changes.
  - Byte accepted on every edge where in_en=1. byte_idx (4-bit) increments on acceptance.
- Pop:
  - When byte_idx==15 and in_en=1: pop head, byte_idx wraps to 0, words_sent+1.
  - If the popped entry's last=1: stream_done=1 in the next cycle only.
- Latency and throughput:
  - Word pushed at edge t into an empty FIFO gives in_en=1 (busy=0, halt=0) in the cycle after t.
  - Back-to-back words stream with no bubble: byte 15 of word n is followed directly by byte 0 of word n+1.
  - One byte/cycle max.
- Simultaneous push and pop in the same edge are both performed; count unchanged.
  - A push when full cannot occur (ready low).
  - A pop when empty cannot occur (in_en low).
- busy or halt high mid-word: byte_idx and head are held. Resumes with the same byte when both are low; no byte is repeated or skipped.
- words_sent wraps modulo 2^CNT_W.
- Two-state FSM on the head entry:
  - EMPTY: no word.
  - SEND: head valid. SEND→EMPTY only on a pop that leaves the FIFO empty.
  - FSM state is equivalent to !empty and must be derived from it, not stored separately.

Decomposition:
- Shared package holds:
  - IOT_WORD_W=128, IOT_BYTE_W=8, IOT_BYTES_PER_WORD=16
  - fn_sel encodings: ENCRYPT=1, DECRYPT=2, CRC_GEN=3, TOP2MAX=4, LAST2MIN=5, for benches pairing feeder and filter
- One sub-module: iot_word_fifo, a synchronous FIFO with DEPTH entries of 129 bits and full/empty flags, reset synchronous.
- Byte mux and counters stay in the top.

Test Plan:
- Single word: push 128'h0F0E..0100 (byte k = k) with last=1, busy=0 → in_en high 16 consecutive cycles starting the cycle after push, iot_in 00,01,…,0F; words_sent=1; stream_done pulses once the cycle after byte 0F.
- Stall: busy=1 for cycles 5–6 of a word → in_en=0 those cycles, byte 05 presented before and after the stall, 16 accepted bytes total, no duplicates.
- Back-to-back: push 4 words with DEPTH=4 while busy=0 → word_ready low once 4 entries are held; 64 contiguous in_en cycles; words_sent=4; stream_done only after the word flagged last.
- Full/simultaneous: hold word_valid=1 with the FIFO full; when byte 15 pops, the new word is accepted the same edge → ready pulses once, count stays DEPTH.
- Reset mid-word: assert rst after byte 07 → next cycle in_en=0, words_sent=0, FIFO empty; a new word then starts at byte 0.
- End-to-end with filter, fn_sel=TOP2MAX: stream 16 words, 8 per round → filter busy honoured with no byte lost; filter outputs match the golden top-2 maxima per round.
